// File: rtl/uart_pkg.sv
// Shared definitions for the register-bus UART responder:
// register offsets, STATUS bit positions and FSM state encodings.
package uart_pkg;

    localparam logic [1:0] UART_TX_DATA = 2'd0;
    localparam logic [1:0] UART_RX_DATA = 2'd1;
    localparam logic [1:0] UART_STATUS  = 2'd2;
    localparam logic [1:0] UART_DIVISOR = 2'd3;

    localparam int ST_TX_FULL      = 0;
    localparam int ST_TX_EMPTY     = 1;
    localparam int ST_TX_ACTIVE    = 2;
    localparam int ST_RX_VALID     = 3;
    localparam int ST_RX_OVERRUN   = 4;
    localparam int ST_RX_FRAME_ERR = 5;

    localparam logic [15:0] MIN_DIVISOR = 16'd3;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_e;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP,
        RX_WAIT_HIGH
    } rx_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO without bypass; push while full is dropped,
// judged before any same-cycle pop. Pop while empty is ignored.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      wr_ptr_d;
    logic [AW:0]      rd_ptr_q;
    logic [AW:0]      rd_ptr_d;
    logic             do_push;
    logic             do_pop;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0])
                && (wr_ptr_q[AW] != rd_ptr_q[AW]);
    assign head  = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        do_push  = push && !full;
        do_pop   = pop && !empty;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, 1'b1};
        if (do_pop)  rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, 1'b1};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/uart_peripheral.sv
// Register-bus UART responder: four registers at BASE_INDEX,
// buffered 8N1 transmit and receive with a shared bit divisor.
module uart_peripheral
    import uart_pkg::*;
#(
    parameter logic [11:0] BASE_INDEX      = 12'h000,
    parameter int          FIFO_DEPTH      = 8,
    parameter logic [15:0] DEFAULT_DIVISOR = 16'd433
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [11:0] register_index,
    input  logic        register_read,
    input  logic        register_write,
    input  logic [15:0] register_write_value,
    output logic [15:0] register_read_value,
    output logic        uart_tx,
    input  logic        uart_rx
);

    logic        hit;
    logic [1:0]  offset;
    logic        wr_en;
    logic        rd_en;
    logic        tx_push;
    logic        rx_pop;
    logic        status_wr;
    logic        div_wr;

    logic [15:0] divisor_q, divisor_d;
    logic        overrun_q, overrun_d;
    logic        frame_err_q, frame_err_d;
    logic [15:0] read_value_q, read_value_d;
    logic [15:0] status;

    logic        tx_full, tx_empty, tx_pop;
    logic [7:0]  tx_head;
    logic        rx_full, rx_empty, rx_push;
    logic [7:0]  rx_head;

    tx_state_e   tx_state_q, tx_state_d;
    logic [15:0] tx_cnt_q, tx_cnt_d;
    logic [15:0] tx_div_q, tx_div_d;
    logic [2:0]  tx_bit_q, tx_bit_d;
    logic [7:0]  tx_shift_q, tx_shift_d;
    logic        tx_line_q, tx_line_d;

    rx_state_e   rx_state_q, rx_state_d;
    logic [15:0] rx_cnt_q, rx_cnt_d;
    logic [15:0] rx_div_q, rx_div_d;
    logic [2:0]  rx_bit_q, rx_bit_d;
    logic [7:0]  rx_shift_q, rx_shift_d;
    logic        rx_meta_q, rx_sync_q, rx_prev_q;
    logic        overrun_set, frame_set;

    assign hit = (register_index >= BASE_INDEX)
              && (register_index <= BASE_INDEX + 12'd3);
    // In range, the low two bits of the difference are the offset.
    assign offset    = register_index[1:0] - BASE_INDEX[1:0];
    assign wr_en     = register_write && hit;
    assign rd_en     = register_read && hit;
    assign tx_push   = wr_en && (offset == UART_TX_DATA);
    assign rx_pop    = wr_en && (offset == UART_RX_DATA);
    assign status_wr = wr_en && (offset == UART_STATUS);
    assign div_wr    = wr_en && (offset == UART_DIVISOR);

    assign register_read_value = read_value_q;
    assign uart_tx             = tx_line_q;

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (tx_push),
        .push_data (register_write_value[7:0]),
        .pop       (tx_pop),
        .head      (tx_head),
        .full      (tx_full),
        .empty     (tx_empty)
    );

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (rx_push),
        .push_data (rx_shift_q),
        .pop       (rx_pop),
        .head      (rx_head),
        .full      (rx_full),
        .empty     (rx_empty)
    );

    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_div_d   = tx_div_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        tx_pop     = 1'b0;
        unique case (tx_state_q)
            TX_IDLE: begin
                if (!tx_empty) begin
                    tx_pop     = 1'b1;
                    tx_state_d = TX_START;
                    tx_shift_d = tx_head;
                    tx_div_d   = divisor_q;
                    tx_cnt_d   = divisor_q;
                end
            end
            TX_START: begin
                if (tx_cnt_q == 16'd0) begin
                    tx_state_d = TX_DATA;
                    tx_bit_d   = 3'd0;
                    tx_cnt_d   = tx_div_q;
                end else begin
                    tx_cnt_d = tx_cnt_q - 16'd1;
                end
            end
            TX_DATA: begin
                if (tx_cnt_q == 16'd0) begin
                    tx_cnt_d = tx_div_q;
                    if (tx_bit_q == 3'd7) begin
                        tx_state_d = TX_STOP;
                    end else begin
                        tx_bit_d   = tx_bit_q + 3'd1;
                        tx_shift_d = {1'b0, tx_shift_q[7:1]};
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q - 16'd1;
                end
            end
            TX_STOP: begin
                if (tx_cnt_q != 16'd0) begin
                    tx_cnt_d = tx_cnt_q - 16'd1;
                end else if (!tx_empty) begin
                    // Back-to-back frame: no idle bit in between.
                    tx_pop     = 1'b1;
                    tx_state_d = TX_START;
                    tx_shift_d = tx_head;
                    tx_div_d   = divisor_q;
                    tx_cnt_d   = divisor_q;
                end else begin
                    tx_state_d = TX_IDLE;
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase

        unique case (tx_state_d)
            TX_START: tx_line_d = 1'b0;
            TX_DATA:  tx_line_d = tx_shift_d[0];
            default:  tx_line_d = 1'b1;
        endcase
    end

    always_comb begin
        rx_state_d  = rx_state_q;
        rx_cnt_d    = rx_cnt_q;
        rx_div_d    = rx_div_q;
        rx_bit_d    = rx_bit_q;
        rx_shift_d  = rx_shift_q;
        rx_push     = 1'b0;
        overrun_set = 1'b0;
        frame_set   = 1'b0;
        unique case (rx_state_q)
            RX_IDLE: begin
                if (rx_prev_q && !rx_sync_q) begin
                    rx_state_d = RX_START;
                    rx_cnt_d   = divisor_q >> 1;
                    rx_div_d   = divisor_q;
                end
            end
            RX_START: begin
                if (rx_cnt_q != 16'd0) begin
                    rx_cnt_d = rx_cnt_q - 16'd1;
                end else if (rx_sync_q) begin
                    rx_state_d = RX_IDLE;
                end else begin
                    rx_state_d = RX_DATA;
                    rx_bit_d   = 3'd0;
                    rx_cnt_d   = rx_div_q;
                end
            end
            RX_DATA: begin
                if (rx_cnt_q == 16'd0) begin
                    rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
                    rx_cnt_d   = rx_div_q;
                    if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
                    else rx_bit_d = rx_bit_q + 3'd1;
                end else begin
                    rx_cnt_d = rx_cnt_q - 16'd1;
                end
            end
            RX_STOP: begin
                if (rx_cnt_q != 16'd0) begin
                    rx_cnt_d = rx_cnt_q - 16'd1;
                end else if (rx_sync_q) begin
                    rx_state_d  = RX_IDLE;
                    rx_push     = !rx_full;
                    overrun_set = rx_full;
                end else begin
                    frame_set  = 1'b1;
                    rx_state_d = RX_WAIT_HIGH;
                end
            end
            RX_WAIT_HIGH: begin
                if (rx_sync_q) rx_state_d = RX_IDLE;
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    always_comb begin
        divisor_d = divisor_q;
        if (div_wr) begin
            divisor_d = (register_write_value < MIN_DIVISOR)
                      ? MIN_DIVISOR : register_write_value;
        end

        // A same-cycle set overrides the write-1-to-clear.
        overrun_d   = overrun_q;
        frame_err_d = frame_err_q;
        if (status_wr && register_write_value[ST_RX_OVERRUN])
            overrun_d = 1'b0;
        if (status_wr && register_write_value[ST_RX_FRAME_ERR])
            frame_err_d = 1'b0;
        if (overrun_set) overrun_d = 1'b1;
        if (frame_set) frame_err_d = 1'b1;

        status                  = '0;
        status[ST_TX_FULL]      = tx_full;
        status[ST_TX_EMPTY]     = tx_empty;
        status[ST_TX_ACTIVE]    = (tx_state_q != TX_IDLE);
        status[ST_RX_VALID]     = !rx_empty;
        status[ST_RX_OVERRUN]   = overrun_q;
        status[ST_RX_FRAME_ERR] = frame_err_q;

        read_value_d = 16'h0000;
        if (rd_en) begin
            unique case (1'b1)
                offset == UART_RX_DATA:
                    read_value_d = rx_empty ? 16'h0000
                                 : {1'b1, 7'b0, rx_head};
                offset == UART_STATUS:
                    read_value_d = status;
                offset == UART_DIVISOR:
                    read_value_d = divisor_q;
                default:
                    read_value_d = 16'h0000;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            divisor_q    <= DEFAULT_DIVISOR;
            overrun_q    <= 1'b0;
            frame_err_q  <= 1'b0;
            read_value_q <= '0;
            tx_state_q   <= TX_IDLE;
            tx_cnt_q     <= '0;
            tx_div_q     <= '0;
            tx_bit_q     <= '0;
            tx_shift_q   <= '0;
            tx_line_q    <= 1'b1;
            rx_state_q   <= RX_IDLE;
            rx_cnt_q     <= '0;
            rx_div_q     <= '0;
            rx_bit_q     <= '0;
            rx_shift_q   <= '0;
            rx_meta_q    <= 1'b1;
            rx_sync_q    <= 1'b1;
            rx_prev_q    <= 1'b1;
        end else begin
            divisor_q    <= divisor_d;
            overrun_q    <= overrun_d;
            frame_err_q  <= frame_err_d;
            read_value_q <= read_value_d;
            tx_state_q   <= tx_state_d;
            tx_cnt_q     <= tx_cnt_d;
            tx_div_q     <= tx_div_d;
            tx_bit_q     <= tx_bit_d;
            tx_shift_q   <= tx_shift_d;
            tx_line_q    <= tx_line_d;
            rx_state_q   <= rx_state_d;
            rx_cnt_q     <= rx_cnt_d;
            rx_div_q     <= rx_div_d;
            rx_bit_q     <= rx_bit_d;
            rx_shift_q   <= rx_shift_d;
            rx_meta_q    <= uart_rx;
            rx_sync_q    <= rx_meta_q;
            rx_prev_q    <= rx_sync_q;
        end
    end

endmodule

// File: tb/tb_uart_peripheral.sv
// Directed bench for uart_peripheral: register table plus
// hand-built TX, loopback, RX error, glitch and overrun sequences.
module tb_uart_peripheral;

    localparam logic [11:0] BASE  = 12'h120;
    localparam logic [11:0] A_TX  = BASE;
    localparam logic [11:0] A_RX  = BASE + 12'd1;
    localparam logic [11:0] A_ST  = BASE + 12'd2;
    localparam logic [11:0] A_DIV = BASE + 12'd3;

    logic        clk = 1'b0;
    logic        reset;
    logic [11:0] register_index;
    logic        register_read;
    logic        register_write;
    logic [15:0] register_write_value;
    logic [15:0] register_read_value;
    logic        uart_tx;
    logic        uart_rx;
    logic        loopback;
    logic        rx_drv;
    logic [15:0] v;
    int          bad;

    int nvec  = 0;
    int nfail = 0;

    typedef struct {
        logic        is_wr;
        logic [11:0] idx;
        logic [15:0] data;
    } vec_t;

    vec_t vt[$];

    assign uart_rx = loopback ? uart_tx : rx_drv;

    always #5 clk = ~clk;

    uart_peripheral #(
        .BASE_INDEX      (BASE),
        .FIFO_DEPTH      (8),
        .DEFAULT_DIVISOR (16'd433)
    ) dut (
        .clk                  (clk),
        .reset                (reset),
        .register_index       (register_index),
        .register_read        (register_read),
        .register_write       (register_write),
        .register_write_value (register_write_value),
        .register_read_value  (register_read_value),
        .uart_tx              (uart_tx),
        .uart_rx              (uart_rx)
    );

    task automatic check(input string nm, input logic [15:0] act,
                         input logic [15:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // All bus tasks are entered on a negedge and return on one.
    task automatic wr(input logic [11:0] idx, input logic [15:0] d);
        register_index       = idx;
        register_write_value = d;
        register_write       = 1'b1;
        @(negedge clk);
        register_write = 1'b0;
    endtask

    task automatic rd(input logic [11:0] idx, output logic [15:0] d);
        register_index = idx;
        register_read  = 1'b1;
        @(negedge clk);
        register_read = 1'b0;
        d = register_read_value;
    endtask

    // Entered on the first clock of a start bit at DIVISOR=3.
    task automatic check_frame(input logic [7:0] b, input string nm);
        logic [9:0] f;
        int         nbad;
        f    = {1'b1, b, 1'b0};
        nbad = 0;
        for (int i = 0; i < 40; i++) begin
            if (uart_tx !== f[i/4]) nbad++;
            @(negedge clk);
        end
        check(nm, 16'(nbad), 16'd0);
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stop);
        logic [9:0] f;
        f = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rx_drv = f[i];
            repeat (4) @(negedge clk);
        end
        rx_drv = 1'b1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vt.push_back('{1'b0, A_ST,  16'h0002});
        vt.push_back('{1'b0, A_DIV, 16'd433});
        vt.push_back('{1'b0, A_TX,  16'h0000});
        vt.push_back('{1'b0, A_RX,  16'h0000});
        vt.push_back('{1'b1, A_DIV, 16'h0000});
        vt.push_back('{1'b0, A_DIV, 16'h0003});
        vt.push_back('{1'b1, A_DIV, 16'h0002});
        vt.push_back('{1'b0, A_DIV, 16'h0003});
        vt.push_back('{1'b1, A_DIV, 16'h1234});
        vt.push_back('{1'b0, A_DIV, 16'h1234});
        vt.push_back('{1'b1, BASE + 12'd7, 16'h0055});
        vt.push_back('{1'b1, BASE - 12'd1, 16'h0077});
        vt.push_back('{1'b0, A_DIV, 16'h1234});
        vt.push_back('{1'b0, BASE + 12'd4, 16'h0000});
        vt.push_back('{1'b1, A_ST,  16'h0030});
        vt.push_back('{1'b0, A_ST,  16'h0002});
        vt.push_back('{1'b1, A_RX,  16'h0000});
        vt.push_back('{1'b0, A_RX,  16'h0000});
        vt.push_back('{1'b0, A_ST,  16'h0002});
        vt.push_back('{1'b1, A_DIV, 16'h0003});
        vt.push_back('{1'b0, A_DIV, 16'h0003});

        reset                = 1'b0;
        register_index       = '0;
        register_read        = 1'b0;
        register_write       = 1'b0;
        register_write_value = '0;
        loopback             = 1'b0;
        rx_drv               = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_tx", {15'b0, uart_tx}, 16'h0001);
        check("reset_rdata", register_read_value, 16'h0000);
        reset = 1'b1;
        @(negedge clk);

        // Abort a frame in flight at the default divisor.
        wr(A_TX, 16'h0055);
        repeat (100) @(negedge clk);
        check("tx_start_bit", {15'b0, uart_tx}, 16'h0000);
        #2 reset = 1'b0;
        #1 check("async_abort_tx", {15'b0, uart_tx}, 16'h0001);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        foreach (vt[i]) begin
            if (vt[i].is_wr) begin
                wr(vt[i].idx, vt[i].data);
            end else begin
                rd(vt[i].idx, v);
                check($sformatf("vec%0d_idx%h", i, vt[i].idx),
                      v, vt[i].data);
            end
        end
        @(negedge clk);
        check("idle_rdata", register_read_value, 16'h0000);

        // Single frame at DIVISOR=3.
        wr(A_TX, 16'h00A5);
        @(negedge clk);
        fork
            check_frame(8'hA5, "frame_a5");
            begin
                repeat (3) @(negedge clk);
                rd(A_ST, v);
                check("status_mid_a5", v, 16'h0006);
            end
        join
        rd(A_ST, v);
        check("status_after_a5", v, 16'h0002);

        // Leader frame keeps TX busy while the burst fills the FIFO.
        wr(A_TX, 16'h00FF);
        fork
            begin
                @(negedge clk);
                check_frame(8'hFF, "burst_lead");
                for (int k = 0; k < 8; k++)
                    check_frame(8'(k), $sformatf("burst_%0d", k));
                bad = 0;
                repeat (45) begin
                    if (uart_tx !== 1'b1) bad++;
                    @(negedge clk);
                end
                check("burst_no_ninth", 16'(bad), 16'd0);
            end
            begin
                for (int k = 0; k < 9; k++) begin
                    register_index       = A_TX;
                    register_write_value = 16'(k);
                    register_write       = 1'b1;
                    @(negedge clk);
                end
                register_write = 1'b0;
                rd(A_ST, v);
                check("burst_full", v, 16'h0005);
            end
        join
        rd(A_ST, v);
        check("burst_done", v, 16'h0002);

        // Loopback.
        loopback = 1'b1;
        wr(A_TX, 16'h003C);
        repeat (60) @(negedge clk);
        loopback = 1'b0;
        rd(A_RX, v);
        check("loop_rx", v, 16'h803C);
        rd(A_ST, v);
        check("loop_status", v, 16'h000A);
        register_index = A_RX;
        register_read  = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check($sformatf("loop_held_%0d", k),
                  register_read_value, 16'h803C);
        end
        register_read = 1'b0;
        rd(A_RX, v);
        check("loop_reread", v, 16'h803C);
        wr(A_RX, 16'hFFFF);
        rd(A_RX, v);
        check("loop_popped", v, 16'h0000);

        // Framing error, then clear.
        send_rx(8'h5A, 1'b0);
        repeat (10) @(negedge clk);
        rd(A_ST, v);
        check("ferr_status", v, 16'h0022);
        rd(A_RX, v);
        check("ferr_fifo", v, 16'h0000);
        wr(A_ST, 16'h0020);
        rd(A_ST, v);
        check("ferr_clear", v, 16'h0002);

        // Two-clock low glitch.
        rx_drv = 1'b0;
        repeat (2) @(negedge clk);
        rx_drv = 1'b1;
        repeat (60) @(negedge clk);
        rd(A_ST, v);
        check("glitch_status", v, 16'h0002);
        rd(A_RX, v);
        check("glitch_fifo", v, 16'h0000);

        // Fill RX FIFO, ninth frame overruns.
        for (int k = 0; k < 9; k++) begin
            send_rx(8'(8'h10 + k), 1'b1);
            repeat (2) @(negedge clk);
        end
        repeat (10) @(negedge clk);
        rd(A_ST, v);
        check("ovr_status", v, 16'h001A);
        rd(A_RX, v);
        check("ovr_head", v, 16'h8010);
        wr(A_ST, 16'h0010);
        rd(A_ST, v);
        check("ovr_clear", v, 16'h000A);
        wr(A_RX, 16'h0000);
        rd(A_RX, v);
        check("ovr_second", v, 16'h8011);

        $display("== %0d vectors applied, %0d miscompares ==",
                 nvec, nfail);
        $finish;
    end

endmodule
